axi_outstanding_limiter: RTL and testbench
==========================================

// Module: axi_outstanding_limiter
// PURPOSE
//  Sits directly upstream of the AXI4 register slice on a card/host memory path.
//  Caps in-flight reads and writes and holds W beats until their AW is accepted, so the
//  downstream register slice and interconnect never see more bursts than they can track.
//  AR/AW/W are gated in place (0-cycle latency); R/B pass straight through; counters are registered.
// PARAMETERS
//  N_OUTSTANDING_RD  8                          max AR bursts accepted without final R beat (>=1)
//  N_OUTSTANDING_WR  8                          max AW bursts accepted without B (>=1)
//  CNT_BITS          $clog2(max(N_RD,N_WR)+1)   counter width (derived, do not override)
// PORTS
//  aclk            in   1         clock
//  areset          in   1         asynchronous reset, active-high
//  s_axi           AXI4.s  -      slave side, from master logic
//  m_axi           AXI4.m  -      master side, to register slice
//  rd_outstanding  out  CNT_BITS  current read bursts in flight
//  wr_outstanding  out  CNT_BITS  current write bursts in flight (AW accepted, B not yet accepted)
//  rd_stall        out  1         s_axi.arvalid high and AR blocked by limit
//  wr_stall        out  1         s_axi.awvalid high and AW blocked by limit
//  proto_err       out  1         sticky: response or W burst with no matching request
// BEHAVIOUR
//  - Reset (async, any time): rd_cnt, wr_cnt, w_credit, proto_err <- 0.
//    While areset is high: m_axi.arvalid/awvalid/wvalid = 0, s_axi.arready/awready/wready = 0.
//    Bursts in flight at reset are dropped; downstream is reset together with this block.
//  - rd_full = (rd_cnt == N_OUTSTANDING_RD); wr_full = (wr_cnt == N_OUTSTANDING_WR).
//  - AR gating:
//    m_axi.arvalid = s_axi.arvalid & ~rd_full; s_axi.arready = m_axi.arready & ~rd_full.
//    AR payload passes through unmodified.
//  - AW gating: same as AR, using wr_full.
//  - W gating:
//    m_axi.wvalid = s_axi.wvalid & (w_credit != 0); s_axi.wready = m_axi.wready & (w_credit != 0).
//    w_credit is registered, so the first W beat leaves no earlier than the cycle after its AW handshake.
//  - R and B channels: pure pass-through in both directions.
//  - Counter updates at posedge (hs = valid & ready on m_axi side):
//    rd_cnt:   +1 on AR hs, -1 on R hs with rlast; both same cycle -> unchanged.
//    wr_cnt:   +1 on AW hs, -1 on B hs; both same cycle -> unchanged.
//    w_credit: +1 on AW hs, -1 on W hs with wlast; both same cycle -> unchanged.
//    Non-last R and W beats do not change any counter.
//  - Bounds:
//    rd_cnt/wr_cnt never exceed their N (gating guarantees it). w_credit <= wr_cnt always.
//    Decrement at 0 (R-last with rd_cnt=0, B with wr_cnt=0): counter holds 0, proto_err <- 1.
//    proto_err stays 1 until reset.
//  - Freed slot timing: an R-last/B hs at cycle t frees a slot; the blocked AR/AW may hand-shake at t+1.
//  - Status: rd_outstanding = rd_cnt, wr_outstanding = wr_cnt.
//    rd_stall = s_axi.arvalid & rd_full; wr_stall = s_axi.awvalid & wr_full.
//  - No ID tracking or reordering; the limit counts bursts regardless of ID.
// TESTING
//  1. N_RD=2; three ARs back-to-back, m_axi.arready=1, no R -> 2 accepted, rd_outstanding=2,
//     rd_stall=1 on 3rd. One R beat with rlast -> 3rd AR accepted the next cycle.
//  2. rd_cnt=1; AR hs and R-last hs in the same cycle -> rd_outstanding stays 1, no stall.
//  3. AR arlen=3 -> 4 R beats. rd_cnt decrements only on beat 4 (rlast), not on beats 1-3.
//  4. s_axi.wvalid high from cycle 0, AW hs at cycle 3 -> m_axi.wvalid=0 through cycle 3.
//     4 beats pass from cycle 4. w_credit=0 after wlast. wr_outstanding=1 until B hs.
//  5. B hs injected with wr_cnt=0 -> proto_err=1, wr_outstanding stays 0.
//     proto_err stays 1 over 100 further cycles.
//  6. rd_cnt=2, wr_cnt=1 mid-burst; assert areset between edges -> all valids/readies 0
//     immediately. After release: counters 0, proto_err 0, new AR accepted.

Source files
------------

// File: rtl/axi_outstanding_limiter.sv
// axi_outstanding_limiter
//   Sits in front of the AXI4 register slice on the card/host memory path.
//   It limits how many read and write bursts can be in flight, so that the
//   register slice and interconnect never receive more bursts than they can
//   track. It also holds back W beats until the matching AW has been accepted.
//   AR, AW and W are gated combinationally, so they add no latency.
//   R and B pass straight through. All counters are registered.
//
// Ports
//   aclk, areset            clock, async active-high reset
//   s_axi_*                 slave side, driven by master logic
//   m_axi_*                 master side, toward the register slice
//   rd_outstanding          read bursts accepted whose final R beat has not been seen
//   wr_outstanding          write bursts accepted whose B has not been seen
//   rd_stall / wr_stall     a request is waiting and is blocked by its limit
//   proto_err               sticky: a response or W burst arrived with no matching request

// Up/down burst counter. When inc and dec occur together the count is unchanged.
// A decrement at zero holds the count at zero and raises uflow.
module olim_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         uflow
);
  assign uflow = dec & (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              cnt <= '0;
    else if (inc & ~dec)                  cnt <= cnt + W'(1);
    else if (dec & ~inc & (cnt != '0))    cnt <= cnt - W'(1);
  end
endmodule

module axi_outstanding_limiter #(
  parameter  int N_OUTSTANDING_RD = 8,
  parameter  int N_OUTSTANDING_WR = 8,
  parameter  int ID_W             = 4,
  parameter  int ADDR_W           = 32,
  parameter  int DATA_W           = 64,
  localparam int CNT_MAX  = (N_OUTSTANDING_RD > N_OUTSTANDING_WR) ? N_OUTSTANDING_RD
                                                                  : N_OUTSTANDING_WR,
  localparam int CNT_BITS = $clog2(CNT_MAX + 1)
) (
  input  logic                aclk,
  input  logic                areset,
  // slave AR
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic [2:0]          s_axi_arprot,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  // slave R
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // slave AW
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  // slave W
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  // slave B
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // master AR
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  // master R
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // master AW
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  // master W
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  // master B
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // status
  output logic [CNT_BITS-1:0] rd_outstanding,
  output logic [CNT_BITS-1:0] wr_outstanding,
  output logic                rd_stall,
  output logic                wr_stall,
  output logic                proto_err
);
  // Counter slots: 0 = reads in flight, 1 = writes in flight, 2 = W credit.
  localparam int C_RD = 0;
  localparam int C_WR = 1;
  localparam int C_WC = 2;

  logic [2:0]               inc_v, dec_v, uflow_v;
  logic [2:0][CNT_BITS-1:0] cnt_v;
  logic                     rd_full, wr_full, w_ok;
  logic                     ar_hs, aw_hs, wlast_hs, rlast_hs, b_hs;

  assign rd_full = (cnt_v[C_RD] == CNT_BITS'(N_OUTSTANDING_RD));
  assign wr_full = (cnt_v[C_WR] == CNT_BITS'(N_OUTSTANDING_WR));
  assign w_ok    = (cnt_v[C_WC] != '0);

  // The counters already read 0 during reset, but the full/credit terms do not
  // block everything then. The explicit areset term keeps every handshake
  // closed while areset is high.
  assign m_axi_arvalid = s_axi_arvalid & ~rd_full & ~areset;
  assign s_axi_arready = m_axi_arready & ~rd_full & ~areset;
  assign m_axi_awvalid = s_axi_awvalid & ~wr_full & ~areset;
  assign s_axi_awready = m_axi_awready & ~wr_full & ~areset;
  assign m_axi_wvalid  = s_axi_wvalid  & w_ok     & ~areset;
  assign s_axi_wready  = m_axi_wready  & w_ok     & ~areset;

  // request payloads pass unmodified
  assign m_axi_arid    = s_axi_arid;
  assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen   = s_axi_arlen;
  assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst;
  assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_awid    = s_axi_awid;
  assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen   = s_axi_awlen;
  assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst;
  assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb   = s_axi_wstrb;
  assign m_axi_wlast   = s_axi_wlast;

  // responses pass straight through in both directions
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast;
  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;
  assign s_axi_bid     = m_axi_bid;
  assign s_axi_bresp   = m_axi_bresp;
  assign s_axi_bvalid  = m_axi_bvalid;
  assign m_axi_bready  = s_axi_bready;

  // Handshakes are observed on the master side. Beats of R and W that are not
  // the last beat of their burst do not change any counter.
  assign ar_hs    = m_axi_arvalid & m_axi_arready;
  assign aw_hs    = m_axi_awvalid & m_axi_awready;
  assign wlast_hs = m_axi_wvalid  & m_axi_wready & m_axi_wlast;
  assign rlast_hs = m_axi_rvalid  & m_axi_rready & m_axi_rlast;
  assign b_hs     = m_axi_bvalid  & m_axi_bready;

  assign inc_v = {aw_hs,    aw_hs, ar_hs};
  assign dec_v = {wlast_hs, b_hs,  rlast_hs};

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    olim_cnt #(.W(CNT_BITS)) u_cnt (
      .clk   (aclk),
      .rst   (areset),
      .inc   (inc_v[i]),
      .dec   (dec_v[i]),
      .cnt   (cnt_v[i]),
      .uflow (uflow_v[i])
    );
  end

  // Gating cannot let a W-last through without credit. That slot is still
  // included, so that any such W burst is reported as an orphan.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)        proto_err <= 1'b0;
    else if (|uflow_v) proto_err <= 1'b1;
  end

  assign rd_outstanding = cnt_v[C_RD];
  assign wr_outstanding = cnt_v[C_WR];
  assign rd_stall       = s_axi_arvalid & rd_full;
  assign wr_stall       = s_axi_awvalid & wr_full;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Bench for axi_outstanding_limiter (N_RD=2, N_WR=3): reset, vector table,
// directed multi-cycle sequences, then random traffic against a queue model.
module tb_axi_outstanding_limiter;
  localparam int NRD = 2;
  localparam int NWR = 3;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CB  = $clog2(((NRD > NWR) ? NRD : NWR) + 1);

  logic aclk = 1'b0;
  logic areset;
  logic [IDW-1:0] s_axi_arid, s_axi_rid, s_axi_awid, s_axi_bid;
  logic [IDW-1:0] m_axi_arid, m_axi_rid, m_axi_awid, m_axi_bid;
  logic [AW-1:0]  s_axi_araddr, s_axi_awaddr, m_axi_araddr, m_axi_awaddr;
  logic [7:0]     s_axi_arlen, s_axi_awlen, m_axi_arlen, m_axi_awlen;
  logic [2:0]     s_axi_arsize, s_axi_awsize, m_axi_arsize, m_axi_awsize;
  logic [1:0]     s_axi_arburst, s_axi_awburst, m_axi_arburst, m_axi_awburst;
  logic [2:0]     s_axi_arprot, s_axi_awprot, m_axi_arprot, m_axi_awprot;
  logic [DW-1:0]  s_axi_rdata, s_axi_wdata, m_axi_rdata, m_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb, m_axi_wstrb;
  logic [1:0]     s_axi_rresp, s_axi_bresp, m_axi_rresp, m_axi_bresp;
  logic s_axi_arvalid, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready;
  logic [CB-1:0] rd_outstanding, wr_outstanding;
  logic rd_stall, wr_stall, proto_err;

  always #5 aclk = ~aclk;

  axi_outstanding_limiter #(
    .N_OUTSTANDING_RD(NRD), .N_OUTSTANDING_WR(NWR),
    .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .rd_stall(rd_stall), .wr_stall(wr_stall), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {m_arvalid, s_arready, m_awvalid, s_awready, m_wvalid, s_wready, rd_stall, wr_stall}
  function automatic logic [7:0] ctl_now();
    return {m_axi_arvalid, s_axi_arready, m_axi_awvalid, s_axi_awready,
            m_axi_wvalid, s_axi_wready, rd_stall, wr_stall};
  endfunction

  // {arv,arr, awv,awr, wv,wrdy,wlast, rv,rlast,rready, bv,bready}
  task automatic set_in(input logic [11:0] v);
    {s_axi_arvalid, m_axi_arready, s_axi_awvalid, m_axi_awready,
     s_axi_wvalid, m_axi_wready, s_axi_wlast, m_axi_rvalid, m_axi_rlast,
     s_axi_rready, m_axi_bvalid, s_axi_bready} = v;
  endtask

  task automatic idle();
    set_in('0);
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arprot = '0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awprot = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_bid = '0; m_axi_bresp = '0;
  endtask

  // Inputs change at posedge+1. Outputs are checked at posedge+5.
  task automatic settle(); #4; endtask
  task automatic step();   @(posedge aclk); #1; endtask

  task automatic do_reset();
    areset = 1'b1;
    idle();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  typedef struct {
    logic [11:0] in;
    logic [7:0]  ctl;
    int          rd;
    int          wr;
  } vec_t;
  vec_t vt[$];

  // reference model: one queue entry per burst
  int rdq[$];
  int wrq[$];
  int wq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state: even with every valid/ready driven high, nothing may pass
    areset = 1'b1;
    idle();
    set_in(12'b11_11_111_111_11);
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_ctl", ctl_now(), 8'h00);
    chk("rst_cnt", {rd_outstanding, wr_outstanding, proto_err}, '0);
    areset = 1'b0;
    idle();

    // vector table, applied back to back from the reset state
    vt.push_back('{12'b11_00_000_000_00, 8'b11_00_00_00, 0, 0});
    vt.push_back('{12'b11_00_000_000_00, 8'b11_00_00_00, 1, 0});
    vt.push_back('{12'b11_00_000_000_00, 8'b00_00_00_10, 2, 0}); // 3rd AR stalls
    vt.push_back('{12'b11_00_000_111_00, 8'b00_00_00_10, 2, 0}); // R-last frees a slot
    vt.push_back('{12'b11_00_000_000_00, 8'b11_00_00_00, 1, 0}); // AR taken next cycle
    vt.push_back('{12'b00_00_000_111_00, 8'b00_00_00_00, 2, 0});
    vt.push_back('{12'b11_00_000_111_00, 8'b11_00_00_00, 1, 0}); // AR + R-last together
    vt.push_back('{12'b00_00_000_101_00, 8'b00_00_00_00, 1, 0}); // non-last R beat
    vt.push_back('{12'b00_11_111_000_00, 8'b00_11_00_00, 1, 0}); // W held, AW taken
    vt.push_back('{12'b00_00_111_000_00, 8'b00_00_11_00, 1, 1}); // W-last uses credit
    vt.push_back('{12'b00_00_111_000_00, 8'b00_00_00_00, 1, 1}); // no credit left
    vt.push_back('{12'b00_00_000_000_11, 8'b00_00_00_00, 1, 1}); // B
    vt.push_back('{12'b00_11_000_000_00, 8'b00_11_00_00, 1, 0});
    vt.push_back('{12'b00_11_000_000_00, 8'b00_11_00_00, 1, 1});
    vt.push_back('{12'b00_11_000_000_00, 8'b00_11_00_00, 1, 2});
    vt.push_back('{12'b00_11_110_000_00, 8'b00_00_11_01, 1, 3}); // AW full
    vt.push_back('{12'b00_10_100_000_00, 8'b00_00_10_01, 1, 3});
    vt.push_back('{12'b10_00_000_000_00, 8'b10_00_00_00, 1, 3});
    foreach (vt[i]) begin
      set_in(vt[i].in);
      settle();
      chk($sformatf("vec%0d_ctl", i), ctl_now(), vt[i].ctl);
      chk($sformatf("vec%0d_cnt", i), {rd_outstanding, wr_outstanding},
          {CB'(vt[i].rd), CB'(vt[i].wr)});
      step();
    end

    // arlen=3: only the 4th (last) R beat retires the burst
    do_reset();
    s_axi_arvalid = 1'b1; m_axi_arready = 1'b1; s_axi_arlen = 8'd3;
    settle();
    chk("len_ar_hs", {m_axi_arvalid, s_axi_arready, m_axi_arlen}, {2'b11, 8'd3});
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      m_axi_rvalid = 1'b1; s_axi_rready = 1'b1; m_axi_rlast = (i == 3);
      m_axi_rdata = DW'(32'hA0 + i);
      settle();
      chk($sformatf("len_beat%0d", i), {rd_outstanding, s_axi_rdata}, {CB'(1), DW'(32'hA0 + i)});
      step();
    end
    idle();
    settle();
    chk("len_done", rd_outstanding, 0);
    step();

    // W held until the cycle after its AW handshake
    do_reset();
    for (int c = 0; c < 10; c++) begin
      s_axi_wvalid = 1'b1; m_axi_wready = 1'b1; s_axi_wlast = (c == 7);
      s_axi_awvalid = (c == 3); m_axi_awready = (c == 3);
      m_axi_bvalid = (c == 9); s_axi_bready = (c == 9);
      settle();
      chk($sformatf("w_c%0d", c), {m_axi_wvalid, s_axi_wready}, {2{(c >= 4) && (c <= 7)}});
      if (c >= 4) chk($sformatf("w_wr_c%0d", c), wr_outstanding, 1);
      step();
    end
    idle();
    settle();
    chk("w_wr_after_b", wr_outstanding, 0);
    step();

    // orphan B sets the sticky error
    do_reset();
    m_axi_bvalid = 1'b1; s_axi_bready = 1'b1;
    settle();
    chk("perr_pre", proto_err, 0);
    step();
    idle();
    settle();
    chk("perr_set", {proto_err, wr_outstanding}, {1'b1, CB'(0)});
    begin
      int held = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        if (proto_err === 1'b1) held++;
      end
      chk("perr_hold", held, 100);
    end

    // async reset mid-traffic, with proto_err still set from the previous test
    set_in(12'b11_00_000_000_00); step();
    set_in(12'b11_00_000_000_00); step();
    set_in(12'b00_11_000_000_00); step();
    set_in(12'b00_00_110_000_00); step();                 // non-last W beat
    set_in(12'b11_11_110_000_00);
    settle();
    chk("ar_pre_ctl", ctl_now(), 8'b00_11_11_10);
    chk("ar_pre_cnt", {rd_outstanding, wr_outstanding, proto_err}, {CB'(2), CB'(1), 1'b1});
    #1 areset = 1'b1;
    #1;
    chk("ar_in_ctl", ctl_now(), 8'h00);
    chk("ar_in_cnt", {rd_outstanding, wr_outstanding, proto_err}, '0);
    idle();
    step();
    areset = 1'b0;
    chk("ar_post_cnt", {rd_outstanding, wr_outstanding, proto_err}, '0);
    set_in(12'b11_00_000_000_00);
    settle();
    chk("ar_post_hs", {m_axi_arvalid, s_axi_arready}, 2'b11);
    step();
    idle();
    chk("ar_post_rd", rd_outstanding, 1);

    // random traffic against the queue model
    do_reset();
    rdq.delete(); wrq.delete(); wq.delete();
    for (int n = 0; n < 1500; n++) begin
      logic arv, arr, awv, awr, wv, wrdy, wl, rv, rl, rr, bv, br;
      logic rfull, wfull, cred;
      logic [7:0] exp_ctl;
      arv = 1'($urandom_range(0, 1)); arr = 1'($urandom_range(0, 1));
      awv = 1'($urandom_range(0, 1)); awr = 1'($urandom_range(0, 1));
      wv  = 1'($urandom_range(0, 1)); wrdy = 1'($urandom_range(0, 1));
      wl  = 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1)); rr = 1'($urandom_range(0, 1));
      rl  = (rdq.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      // B only for a write whose data has already completed
      bv  = (wrq.size() > wq.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
      br  = 1'($urandom_range(0, 1));
      set_in({arv, arr, awv, awr, wv, wrdy, wl, rv, rl, rr, bv, br});
      s_axi_araddr = $urandom; s_axi_arlen = 8'($urandom_range(0, 15));
      m_axi_rdata  = $urandom;
      rfull = (rdq.size() == NRD);
      wfull = (wrq.size() == NWR);
      cred  = (wq.size() != 0);
      exp_ctl = {arv & ~rfull, arr & ~rfull, awv & ~wfull, awr & ~wfull,
                 wv & cred, wrdy & cred, arv & rfull, awv & wfull};
      settle();
      chk("rnd_ctl", ctl_now(), exp_ctl);
      chk("rnd_cnt", {rd_outstanding, wr_outstanding, proto_err},
          {CB'(rdq.size()), CB'(wrq.size()), 1'b0});
      chk("rnd_pass", {m_axi_araddr, s_axi_rdata}, {s_axi_araddr, m_axi_rdata});
      if (arv && arr && !rfull) rdq.push_back(int'(s_axi_arlen));
      if (rv && rr && rl) void'(rdq.pop_front());
      if (awv && awr && !wfull) begin wrq.push_back(n); wq.push_back(n); end
      if (wv && wrdy && wl && cred) void'(wq.pop_front());
      if (bv && br) void'(wrq.pop_front());
      step();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
